func_gen_freq_sel: RTL and testbench
====================================

Name: func_gen_freq_sel

Overview:
- Digital function generator with a programmable frequency selector.
- An 8-bit 74193-style up-counter with parallel load divides clk. Its overflow toggles a JK-style flip-flop to form dividedClock.
- The rising edges of dividedClock advance an 8-bit phase accumulator. A waveform mux driven by sel maps the phase to an 8-bit sample on out, which feeds a DAC or scope.

Parameters:
- WIDTH, 8, width of the divider counter, pl, phase and out. All arithmetic below is written for 8.

Ports:
- clk  input  1  system clock; every flop is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- JKReset  input  1  synchronous, active-low clear of the divided-clock flip-flop.
- preset  input  1  divider enable (active-high); 0 freezes the divider.
- pl  input  8  parallel-load value for the divider counter.
- sel  input  3  waveform select.
- out  output  8  registered waveform sample.
- dividedClock  output  1  divided clock (toggle flop output).
- count74193  output  8  current divider count.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1): cnt=0, dividedClock=0, phase=0, out=0. rst has priority over all other inputs.
- Divider, when preset=1 and rst=0:
  - If cnt==255: cnt<=pl and tick=1.
  - Otherwise: cnt<=cnt+1 and tick=0.
  - tick period is (256-pl) clk cycles once running.
  - pl=255 gives a tick every cycle.
  - pl is sampled only at reload; a change mid-count takes effect at the next wrap.
- Divider, when preset=0: cnt holds, tick=0.
- count74193 = cnt, combinational from the register.
- Toggle flop:
  - JKReset=0 → dividedClock<=0 (priority below rst).
  - Otherwise, on tick, dividedClock<=~dividedClock.
  - dividedClock period = 2*(256-pl) clk cycles.
- Phase accumulator:
  - Advances by 1 when tick=1 and dividedClock=0 (the rising-toggle cycle), with JKReset=1.
  - Wraps 255→0.
  - Holds whenever preset=0 or JKReset=0.
- Waveform, with x=phase[6:0] and h=(x*(127-x)) (13-bit unsigned):
  - 000 sawtooth: phase.
  - 001 square: phase[7] ? 0 : 255.
  - 010 triangle: phase[7] ? ~{x,1'b0} : {x,1'b0}.
  - 011 sine (parabolic): phase[7] ? 128-(h>>5) : 128+(h>>5).
  - 100 full-wave rectified: h>>4.
  - 101 half-wave rectified: phase[7] ? 0 : h>>4.
  - 110 reverse sawtooth: 255-phase.
  - 111 25% pulse: phase[7:6]==0 ? 255 : 0.
- Waveform value ranges:
  - h max 4032; h>>5 max 126; h>>4 max 252.
  - No overflow; all results fit in 8 bits.
- out is registered: out<=wave(sel, phase) every clk cycle not in reset, so out lags phase/sel by 1 cycle.
- A sel change takes effect on the next clk edge with no phase disturbance.

Decomposition:
- Shared package: WIDTH, the SEL_* encodings (SAW=0 … PULSE=7), and the reload constant 255.
- One natural sub-module: clock_divider_74193, containing cnt, reload, tick and the toggle flop, with outputs tick, dividedClock and count74193.
- Waveform mux and phase accumulator stay in the top level.

Test Plan:
- Reset: rst=1 for 3 cycles with preset=0 and JKReset=0 → out=0, count74193=0, dividedClock=0. Then preset=1, JKReset=1, pl=150 → count74193 rises 1, 2, … until 255, then reloads to 150. The first-run tick comes after 255 cycles, then every 106 cycles.
- Frequency: pl=145/150/155 on three instances → dividedClock periods 222/212/202 clk cycles. Phase increments once per dividedClock period.
- Waveforms at fixed phase, sel=0..7:
  - phase=64 → 64, 255, 128, 254, 252, 252, 191, 0.
  - phase=192 → 192, 0, 127, 2, 252, 0, 63, 0.
- preset=0 mid-count (cnt=200) for 50 cycles → cnt, dividedClock and phase frozen. Counting resumes from 200 when preset returns to 1.
- Clears:
  - JKReset=0 while dividedClock=1 → dividedClock=0 on the next edge; phase holds.
  - rst=1 mid-operation → all outputs 0 after one edge.
- Sweep sel 0→7 every 120000 cycles with pl=150 → each full waveform period is 256*212 cycles. The triangle peak is 255 at phase=128; the sine minimum is 2 at phase=192.

Source files
------------

// File: rtl/func_gen_freq_sel_pkg.sv
// Shared constants and waveform-select encodings for the function generator.
package func_gen_freq_sel_pkg;

  localparam int DATA_WIDTH = 8;
  // Terminal count of the divider; reaching it reloads from pl and emits a tick.
  localparam int RELOAD_VAL = 255;

  typedef enum logic [2:0] {
    SEL_SAW       = 3'd0,
    SEL_SQUARE    = 3'd1,
    SEL_TRIANGLE  = 3'd2,
    SEL_SINE      = 3'd3,
    SEL_FULL_RECT = 3'd4,
    SEL_HALF_RECT = 3'd5,
    SEL_REV_SAW   = 3'd6,
    SEL_PULSE     = 3'd7
  } sel_e;

endpackage

// File: rtl/func_gen_freq_sel_clock_divider_74193.sv
// 74193-style loadable up-counter feeding a JK toggle flop that forms the divided clock.
module clock_divider_74193
  import func_gen_freq_sel_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             JKReset,
  input  logic             preset,
  input  logic [WIDTH-1:0] pl,
  output logic             tick,
  output logic             dividedClock,
  output logic [WIDTH-1:0] count74193
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;

  // pl is only looked at on the wrap cycle, so mid-count changes wait for the next reload.
  assign tick = preset && (cnt_q == WIDTH'(RELOAD_VAL));

  always_comb begin
    cnt_d = cnt_q;
    if (preset) begin
      cnt_d = tick ? pl : cnt_q + WIDTH'(1);
    end
  end

  always_comb begin
    div_d = div_q;
    if (!JKReset) begin
      div_d = 1'b0;
    end else if (tick) begin
      div_d = ~div_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign dividedClock = div_q;
  assign count74193   = cnt_q;

endmodule

// File: rtl/func_gen_freq_sel.sv
// Function generator: divided clock advances a phase accumulator; sel picks the waveform.
module func_gen_freq_sel
  import func_gen_freq_sel_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             JKReset,
  input  logic             preset,
  input  logic [WIDTH-1:0] pl,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             dividedClock,
  output logic [WIDTH-1:0] count74193
);

  localparam int XW = WIDTH - 1;
  localparam int HW = 2 * XW - 1;

  logic             tick;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [XW-1:0]    x, x_c;
  logic [HW-1:0]    h;
  logic [WIDTH-1:0] h_div32, h_div16;

  clock_divider_74193 #(.WIDTH(WIDTH)) u_div (
    .clk          (clk),
    .rst          (rst),
    .JKReset      (JKReset),
    .preset       (preset),
    .pl           (pl),
    .tick         (tick),
    .dividedClock (dividedClock),
    .count74193   (count74193)
  );

  // Phase steps only on the tick that takes dividedClock from 0 to 1.
  always_comb begin
    phase_d = phase_q;
    if (JKReset && tick && !dividedClock) begin
      phase_d = phase_q + WIDTH'(1);
    end
  end

  // x*(127-x): 127-x on a 7-bit value is just its complement.
  always_comb begin
    x       = phase_q[XW-1:0];
    x_c     = ~x;
    h       = HW'({{XW{1'b0}}, x} * {{XW{1'b0}}, x_c});
    h_div32 = WIDTH'(h >> 5);
    h_div16 = WIDTH'(h >> 4);
  end

  always_comb begin
    out_d = '0;
    case (sel_e'(sel))
      SEL_SAW:       out_d = phase_q;
      SEL_SQUARE:    out_d = phase_q[WIDTH-1] ? '0 : '1;
      SEL_TRIANGLE:  out_d = {x, 1'b0} ^ {WIDTH{phase_q[WIDTH-1]}};
      SEL_SINE:      out_d = phase_q[WIDTH-1] ? WIDTH'(1 << XW) - h_div32
                                              : WIDTH'(1 << XW) + h_div32;
      SEL_FULL_RECT: out_d = h_div16;
      SEL_HALF_RECT: out_d = phase_q[WIDTH-1] ? '0 : h_div16;
      SEL_REV_SAW:   out_d = ~phase_q;
      SEL_PULSE:     out_d = (phase_q[WIDTH-1:WIDTH-2] == 2'b00) ? '1 : '0;
      default:       out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      out_q   <= '0;
    end else begin
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_func_gen_freq_sel.sv
// Self-checking bench: behavioural model, waveform vector table and hand-built corner sequences.
module tb_func_gen_freq_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       JKReset = 1'b0;
  logic       preset = 1'b0;
  logic [7:0] pl = 8'd0;
  logic [2:0] sel = 3'd0;
  logic [7:0] out;
  logic       dividedClock;
  logic [7:0] count74193;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: divider count, divided-clock level, phase, registered sample.
  int m_cnt = 0;
  int m_div = 0;
  int m_phase = 0;
  int m_out = 0;
  bit m_valid = 1'b0;

  func_gen_freq_sel dut (
    .clk          (clk),
    .rst          (rst),
    .JKReset      (JKReset),
    .preset       (preset),
    .pl           (pl),
    .sel          (sel),
    .out          (out),
    .dividedClock (dividedClock),
    .count74193   (count74193)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waveform shapes straight from their arithmetic definitions.
  function automatic int ref_wave(input int s, input int p);
    int x;
    int h;
    bit hi;
    x  = p % 128;
    h  = x * (127 - x);
    hi = (p >= 128);
    case (s)
      0:       return p;
      1:       return hi ? 0 : 255;
      2:       return hi ? 255 - 2 * x : 2 * x;
      3:       return hi ? 128 - h / 32 : 128 + h / 32;
      4:       return h / 16;
      5:       return hi ? 0 : h / 16;
      6:       return 255 - p;
      default: return (p < 64) ? 255 : 0;
    endcase
  endfunction

  // One clock: predict from pre-edge inputs, clock, then compare all outputs.
  task automatic cycle();
    int n_cnt, n_div, n_phase, n_out;
    bit tick;
    if (rst) begin
      n_cnt = 0; n_div = 0; n_phase = 0; n_out = 0;
    end else begin
      tick    = preset && (m_cnt == 255);
      n_out   = ref_wave(int'(sel), m_phase);
      n_cnt   = !preset ? m_cnt : (tick ? int'(pl) : m_cnt + 1);
      n_phase = (JKReset && tick && m_div == 0) ? (m_phase + 1) % 256 : m_phase;
      n_div   = !JKReset ? 0 : (tick ? 1 - m_div : m_div);
    end
    @(posedge clk);
    #1;
    if (rst) m_valid = 1'b1;
    m_cnt = n_cnt; m_div = n_div; m_phase = n_phase; m_out = n_out;
    if (m_valid) begin
      check("model_count74193", int'(count74193), m_cnt);
      check("model_dividedClock", int'(dividedClock), m_div);
      check("model_out", int'(out), m_out);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  // Clocks until dividedClock rises; n = cycles taken, or -1 on timeout.
  task automatic wait_rise(input int limit, output int n);
    bit prev;
    for (n = 1; n <= limit; n++) begin
      prev = dividedClock;
      cycle();
      if (!prev && dividedClock === 1'b1) return;
    end
    n = -1;
    check("wait_rise_timeout", 0, 1);
  endtask

  typedef struct {
    int phase;
    int sel;
    int exp_out;
  } wave_vec_t;

  typedef struct {
    int pl;
    int period;
  } freq_vec_t;

  wave_vec_t wvec[19];
  freq_vec_t fvec[3];

  initial begin
    int n, n2, o1, o2, hold_out, hold_div, cur_phase;
    bit hit;

    wvec[0]  = '{64, 0, 64};   wvec[1]  = '{64, 1, 255};  wvec[2]  = '{64, 2, 128};
    wvec[3]  = '{64, 3, 254};  wvec[4]  = '{64, 4, 252};  wvec[5]  = '{64, 5, 252};
    wvec[6]  = '{64, 6, 191};  wvec[7]  = '{64, 7, 0};
    wvec[8]  = '{192, 0, 192}; wvec[9]  = '{192, 1, 0};   wvec[10] = '{192, 2, 127};
    wvec[11] = '{192, 3, 2};   wvec[12] = '{192, 4, 252}; wvec[13] = '{192, 5, 0};
    wvec[14] = '{192, 6, 63};  wvec[15] = '{192, 7, 0};
    wvec[16] = '{128, 2, 255}; wvec[17] = '{128, 3, 128}; wvec[18] = '{128, 0, 128};
    fvec[0]  = '{145, 222};    fvec[1]  = '{150, 212};    fvec[2]  = '{155, 202};

    // Reset with divider and flop disabled.
    preset = 1'b0; JKReset = 1'b0;
    do_reset(3);
    check("reset_out", int'(out), 0);
    check("reset_count", int'(count74193), 0);
    check("reset_div", int'(dividedClock), 0);
    $display("reset: out=%0d count=%0d div=%0d", out, count74193, dividedClock);

    // Count up from 0 to the terminal count, then reload from pl.
    preset = 1'b1; JKReset = 1'b1; pl = 8'd150;
    for (int i = 1; i <= 255; i++) begin
      cycle();
      check("countup", int'(count74193), i);
    end
    cycle();
    check("reload_value", int'(count74193), 150);
    check("first_tick_toggle", int'(dividedClock), 1);
    $display("count-up: reloaded to %0d, div=%0d", count74193, dividedClock);

    // Freeze at count 200.
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (count74193 == 8'd200) hit = 1'b1;
      else cycle();
    end
    check("reach_200", int'(hit), 1);
    preset = 1'b0;
    cycle();
    hold_out = int'(out); hold_div = int'(dividedClock);
    for (int i = 0; i < 49; i++) begin
      cycle();
      check("freeze_count", int'(count74193), 200);
      check("freeze_div", int'(dividedClock), hold_div);
      check("freeze_out", int'(out), hold_out);
    end
    preset = 1'b1;
    cycle();
    check("resume_201", int'(count74193), 201);
    $display("freeze: held at 200, resumed to %0d", count74193);

    // JK clear while dividedClock is high; phase (seen via sawtooth) holds.
    sel = 3'd0;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (dividedClock === 1'b1) hit = 1'b1;
      else cycle();
    end
    check("reach_div_high", int'(hit), 1);
    JKReset = 1'b0;
    cycle();
    check("jk_clear", int'(dividedClock), 0);
    hold_out = int'(out);
    for (int i = 0; i < 300; i++) begin
      cycle();
      check("jk_phase_hold", int'(out), hold_out);
      check("jk_div_low", int'(dividedClock), 0);
    end
    JKReset = 1'b1;
    $display("jk clear: div=%0d, saw held at %0d", dividedClock, out);

    // Reset mid-operation.
    repeat (20) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_out", int'(out), 0);
    check("midrst_count", int'(count74193), 0);
    check("midrst_div", int'(dividedClock), 0);
    $display("mid reset: out=%0d count=%0d div=%0d", out, count74193, dividedClock);

    // Divided-clock period and one phase step per period.
    foreach (fvec[k]) begin
      do_reset(2);
      preset = 1'b1; JKReset = 1'b1; pl = 8'(fvec[k].pl); sel = 3'd0;
      wait_rise(1000, n);
      o1 = int'(out);
      wait_rise(1000, n2);
      o2 = int'(out);
      check("div_period", n2, fvec[k].period);
      check("phase_step", o2, (o1 + 1) % 256);
      $display("freq pl=%0d: period=%0d phase %0d->%0d", fvec[k].pl, n2, o1, o2);
    end

    // Waveform table at frozen phases.
    cur_phase = -1;
    foreach (wvec[k]) begin
      if (wvec[k].phase != cur_phase) begin
        do_reset(2);
        preset = 1'b1; JKReset = 1'b1; pl = 8'd255;
        for (int i = 0; i < 2000 && m_phase != wvec[k].phase; i++) cycle();
        check("reach_phase", m_phase, wvec[k].phase);
        preset = 1'b0;
        cur_phase = wvec[k].phase;
      end
      sel = 3'(wvec[k].sel);
      cycle();
      check("wave_table", int'(out), wvec[k].exp_out);
      $display("wave phase=%0d sel=%0d: out=%0d exp=%0d",
               wvec[k].phase, wvec[k].sel, out, wvec[k].exp_out);
    end

    // Randomized traffic against the model.
    do_reset(2);
    for (int i = 0; i < 6000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      preset  = ($urandom_range(0, 9) != 0);
      JKReset = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 19) == 0) sel = 3'($urandom);
      pl = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(240, 255));
      cycle();
    end
    rst = 1'b0;
    $display("random: 6000 cycles compared against model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
